// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command to the registered ALU, waits its latency, and returns the captured result.
module alu_cmd_sequencer #(
    parameter int WIDTH       = 16,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_opcode,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_b,
    output logic [WIDTH-1:0]     alu_in0,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [2:0]           alu_opcode,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_overflow,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] ovf_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    always_comb begin
        state_nxt = (state == IDLE && cmd_valid) ? WAIT :
                    (state == WAIT && cnt == 4'd0) ? RESP :
                    (state == RESP && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            alu_in0      <= '0;
            alu_in1      <= '0;
            alu_opcode   <= '0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            rsp_valid    <= 1'b0;
            ovf_count    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cmd_valid) begin
                alu_in0    <= cmd_a;
                alu_in1    <= cmd_b;
                alu_opcode <= cmd_opcode;
                cnt        <= 4'(ALU_LATENCY);
            end
            if (state == WAIT) begin
                if (cnt == 4'd0) begin
                    rsp_data     <= alu_out;
                    rsp_overflow <= alu_overflow;
                    rsp_valid    <= 1'b1;
                    if (alu_overflow && ~&ovf_count) ovf_count <= ovf_count + 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule
